// File: rtl/instruction_encoder_if.sv
// Request and instruction-memory write bundle for instruction_encoder.
// master drives requests and memory readiness; slave is the encoder.
interface instruction_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_mnem;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_mnem, in_rs, in_rt, in_rd,
        output in_imm, in_last, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_mnem, in_rs, in_rt, in_rd,
        input  in_imm, in_last, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instruction_encoder.sv
// Packs field-level requests into MIPS words and streams them
// through a small FIFO into instruction memory.
module instruction_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    instruction_encoder_if.slave bus,
    output logic [ADDR_W:0]     wcount,
    output logic                done,
    output logic                err
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_N = (PW+1)'(DEPTH);
    localparam logic [ADDR_W:0] WMAX = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [31:0]       mem [DEPTH];
    logic [PW:0]       wptr;
    logic [PW:0]       rptr;
    logic [PW:0]       count;
    logic              full;
    logic              empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic [31:0]       word;
    logic              word_ok;
    logic [ADDR_W-1:0] addr_q;

    assign count  = wptr - rptr;
    assign empty  = (count == '0);
    assign full   = (count == FULL_N);
    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && word_ok;
    assign pop    = bus.imem_we && bus.imem_ready;
    assign done   = (state == S_DONE);

    assign bus.imem_we    = !empty;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = empty ? '0 : mem[rptr[PW-1:0]];

    always_comb begin
        word    = '0;
        word_ok = 1'b1;
        case (bus.in_mnem)
            3'd0: word = {6'h00, bus.in_rs, bus.in_rt,
                          bus.in_rd, 5'd0, 6'h20};
            3'd1: word = {6'h00, bus.in_rs, bus.in_rt,
                          bus.in_rd, 5'd0, 6'h21};
            3'd2: word = {6'h00, bus.in_rs, bus.in_rt,
                          bus.in_rd, 5'd0, 6'h22};
            3'd3: word = {6'h00, bus.in_rs, bus.in_rt,
                          bus.in_rd, 5'd0, 6'h24};
            3'd4: word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
            3'd5: word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
            3'd6: word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
            default: word_ok = 1'b0;
        endcase
    end

    // Readiness ignores a same-cycle pop so it never depends on imem_ready.
    always_comb begin
        bus.in_ready = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE:  bus.in_ready = 1'b1;
                S_RUN:   bus.in_ready = !full;
                default: bus.in_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept)
                    state_n = bus.in_last ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                if (accept && bus.in_last)
                    state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (empty)
                    state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            addr_q <= BASE;
            wcount <= '0;
            err    <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (accept && !word_ok)
                err <= 1'b1;
            // FIFO is always empty in IDLE, so no pop can collide here.
            if (accept && state == S_IDLE) begin
                addr_q <= BASE;
                wcount <= '0;
            end else if (pop) begin
                addr_q <= addr_q + 1'b1;
                if (wcount != WMAX)
                    wcount <= wcount + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[PW-1:0]] <= word;
    end
endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: encodings, backpressure,
// invalid mnemonics, reset mid-program and address wrap.
module tb_instruction_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  in_mnem = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [15:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        imem_ready = 1'b0;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    instruction_encoder_if #(.ADDR_W(8)) ia ();
    instruction_encoder_if #(.ADDR_W(8)) ib ();

    assign ia.in_valid   = in_valid;
    assign ia.in_mnem    = in_mnem;
    assign ia.in_rs      = in_rs;
    assign ia.in_rt      = in_rt;
    assign ia.in_rd      = in_rd;
    assign ia.in_imm     = in_imm;
    assign ia.in_last    = in_last;
    assign ia.imem_ready = imem_ready;
    assign ib.in_valid   = in_valid;
    assign ib.in_mnem    = in_mnem;
    assign ib.in_rs      = in_rs;
    assign ib.in_rt      = in_rt;
    assign ib.in_rd      = in_rd;
    assign ib.in_imm     = in_imm;
    assign ib.in_last    = in_last;
    assign ib.imem_ready = imem_ready;

    logic [8:0] wcount_a;
    logic [8:0] wcount_b;
    logic       done_a;
    logic       done_b;
    logic       err_a;
    logic       err_b;

    instruction_encoder #(
        .DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)
    ) ua (
        .clk(clk), .rst(rst), .bus(ia),
        .wcount(wcount_a), .done(done_a), .err(err_a)
    );

    instruction_encoder #(
        .DEPTH(4), .ADDR_W(8), .BASE_ADDR(254)
    ) ub (
        .clk(clk), .rst(rst), .bus(ib),
        .wcount(wcount_b), .done(done_b), .err(err_b)
    );

    logic [31:0] qa_data[$];
    logic [7:0]  qa_addr[$];
    logic [7:0]  qb_addr[$];
    int          na_done = 0;
    int          nb_done = 0;

    // Write/done monitor: records every completed memory write.
    always @(posedge clk) begin
        if (ia.imem_we && imem_ready) begin
            qa_data.push_back(ia.imem_wdata);
            qa_addr.push_back(ia.imem_addr);
        end
        if (ib.imem_we && imem_ready)
            qb_addr.push_back(ib.imem_addr);
        if (done_a)
            na_done <= na_done + 1;
        if (done_b)
            nb_done <= nb_done + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send(input logic [2:0] m, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d,
                        input logic [15:0] im, input logic l);
        int n = 0;
        while (!ia.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_mnem  = m;
        in_rs    = s;
        in_rt    = t;
        in_rd    = d;
        in_imm   = im;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, input int start);
        for (int i = 0; i < 60; i++) begin
            if ((use_b ? nb_done : na_done) != start)
                break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (ia.in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", ia.in_ready); else passed++;
        total++; if (ia.imem_we !== 1'b0) $display("FAIL rst_we got %b want 0", ia.imem_we); else passed++;
        total++; if (ia.imem_addr !== 8'h00) $display("FAIL rst_addr got %h want 00", ia.imem_addr); else passed++;
        total++; if (ib.imem_addr !== 8'hFE) $display("FAIL rst_addr_b got %h want fe", ib.imem_addr); else passed++;
        total++; if (ia.imem_wdata !== 32'h0) $display("FAIL rst_wdata got %h want 0", ia.imem_wdata); else passed++;
        total++; if (wcount_a !== 9'd0) $display("FAIL rst_wcount got %0d want 0", wcount_a); else passed++;
        total++; if (done_a !== 1'b0) $display("FAIL rst_done got %b want 0", done_a); else passed++;
        total++; if (err_a !== 1'b0 || err_b !== 1'b0) $display("FAIL rst_err got %b%b want 00", err_a, err_b); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (ia.in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b want 1", ia.in_ready); else passed++;
    endtask

    task automatic test_encode();
        int b = qa_data.size();
        int d0 = na_done;
        imem_ready = 1'b1;
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        total++; if (ia.imem_we !== 1'b1) $display("FAIL lat_we got %b want 1", ia.imem_we); else passed++;
        total++; if (ia.imem_wdata !== 32'h00221820) $display("FAIL lat_wdata got %h want 00221820", ia.imem_wdata); else passed++;
        send(3'd4, 5'd0, 5'd8, 5'd0, 16'h5, 1'b1);
        wait_done(1'b0, d0);
        total++; if (qa_data.size() - b !== 2) $display("FAIL enc_nwrites got %0d want 2", qa_data.size() - b); else passed++;
        total++; if (qa_data[b] !== 32'h00221820) $display("FAIL enc_w0 got %h want 00221820", qa_data[b]); else passed++;
        total++; if (qa_data[b+1] !== 32'h20080005) $display("FAIL enc_w1 got %h want 20080005", qa_data[b+1]); else passed++;
        total++; if (qa_addr[b] !== 8'h00 || qa_addr[b+1] !== 8'h01) $display("FAIL enc_addr got %h,%h want 00,01", qa_addr[b], qa_addr[b+1]); else passed++;
        total++; if (na_done - d0 !== 1) $display("FAIL enc_done got %0d pulses want 1", na_done - d0); else passed++;
        total++; if (wcount_a !== 9'd2) $display("FAIL enc_wcount got %0d want 2", wcount_a); else passed++;
    endtask

    task automatic test_all_ops();
        logic [31:0] exp [4] = '{32'h00853022, 32'h00210824, 32'h8FA90004, 32'hAFA90008};
        int b = qa_data.size();
        int d0 = na_done;
        imem_ready = 1'b1;
        send(3'd2, 5'd4, 5'd5, 5'd6, 16'h0, 1'b0);
        send(3'd3, 5'd1, 5'd1, 5'd1, 16'h0, 1'b0);
        send(3'd5, 5'd29, 5'd9, 5'd0, 16'h4, 1'b0);
        send(3'd6, 5'd29, 5'd9, 5'd0, 16'h8, 1'b1);
        wait_done(1'b0, d0);
        total++; if (qa_data.size() - b !== 4) $display("FAIL ops_nwrites got %0d want 4", qa_data.size() - b); else passed++;
        for (int k = 0; k < 4; k++) begin
            total++; if (qa_data[b+k] !== exp[k]) $display("FAIL ops_w%0d got %h want %h", k, qa_data[b+k], exp[k]); else passed++;
        end
        total++; if (wcount_a !== 9'd4) $display("FAIL ops_wcount got %0d want 4", wcount_a); else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [5] = '{32'h20000001, 32'h20000002, 32'h8C000003, 32'h20000004, 32'h20000005};
        int b = qa_data.size();
        int d0 = na_done;
        int i = 0;
        imem_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (i < 5 && ia.in_ready) begin
                in_valid = 1'b1;
                in_mnem  = (i == 2) ? 3'd5 : 3'd4;
                in_rs    = 5'd0;
                in_rt    = 5'd0;
                in_imm   = 16'(i + 1);
                in_last  = (i == 4);
                i++;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++; if (i !== 4) $display("FAIL bp_accepts got %0d want 4", i); else passed++;
        total++; if (ia.in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", ia.in_ready); else passed++;
        total++; if (ia.imem_wdata !== 32'h20000001) $display("FAIL bp_hold_wdata got %h want 20000001", ia.imem_wdata); else passed++;
        total++; if (ia.imem_we !== 1'b1 || ia.imem_addr !== 8'h00) $display("FAIL bp_hold_we_addr got %b/%h want 1/00", ia.imem_we, ia.imem_addr); else passed++;
        total++; if (qa_data.size() !== b) $display("FAIL bp_no_write got %0d want 0", qa_data.size() - b); else passed++;
        imem_ready = 1'b1;
        send(3'd4, 5'd0, 5'd0, 5'd0, 16'h5, 1'b1);
        wait_done(1'b0, d0);
        total++; if (qa_data.size() - b !== 5) $display("FAIL bp_nwrites got %0d want 5", qa_data.size() - b); else passed++;
        for (int k = 0; k < 5; k++) begin
            total++; if (qa_data[b+k] !== exp[k] || qa_addr[b+k] !== 8'(k)) $display("FAIL bp_w%0d got %h@%h want %h@%h", k, qa_data[b+k], qa_addr[b+k], exp[k], 8'(k)); else passed++;
        end
    endtask

    task automatic test_invalid();
        int b = qa_data.size();
        int d0 = na_done;
        imem_ready = 1'b1;
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        send(3'd7, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        send(3'd6, 5'd29, 5'd9, 5'd0, 16'h8, 1'b1);
        wait_done(1'b0, d0);
        total++; if (qa_data.size() - b !== 2) $display("FAIL inv_nwrites got %0d want 2", qa_data.size() - b); else passed++;
        total++; if (qa_data[b] !== 32'h00221820 || qa_data[b+1] !== 32'hAFA90008) $display("FAIL inv_words got %h,%h want 00221820,afa90008", qa_data[b], qa_data[b+1]); else passed++;
        total++; if (qa_addr[b] !== 8'h00 || qa_addr[b+1] !== 8'h01) $display("FAIL inv_addr got %h,%h want 00,01", qa_addr[b], qa_addr[b+1]); else passed++;
        total++; if (err_a !== 1'b1) $display("FAIL inv_err got %b want 1", err_a); else passed++;
        total++; if (na_done - d0 !== 1) $display("FAIL inv_done got %0d pulses want 1", na_done - d0); else passed++;
        d0 = na_done;
        send(3'd4, 5'd0, 5'd8, 5'd0, 16'h5, 1'b1);
        wait_done(1'b0, d0);
        total++; if (err_a !== 1'b1) $display("FAIL inv_err_sticky got %b want 1", err_a); else passed++;
        total++; if (na_done - d0 !== 1) $display("FAIL inv_done2 got %0d pulses want 1", na_done - d0); else passed++;
    endtask

    task automatic test_reset_mid();
        int b;
        int d0;
        imem_ready = 1'b0;
        send(3'd4, 5'd0, 5'd0, 5'd0, 16'h1, 1'b0);
        send(3'd4, 5'd0, 5'd0, 5'd0, 16'h2, 1'b0);
        send(3'd4, 5'd0, 5'd0, 5'd0, 16'h3, 1'b0);
        total++; if (ia.imem_we !== 1'b1) $display("FAIL rm_queued_we got %b want 1", ia.imem_we); else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++; if (ia.imem_we !== 1'b0) $display("FAIL rm_we got %b want 0", ia.imem_we); else passed++;
        total++; if (wcount_a !== 9'd0 || err_a !== 1'b0) $display("FAIL rm_wcount_err got %0d/%b want 0/0", wcount_a, err_a); else passed++;
        rst = 1'b0;
        imem_ready = 1'b1;
        b = qa_data.size();
        repeat (4) @(negedge clk);
        total++; if (qa_data.size() !== b) $display("FAIL rm_no_write got %0d want 0", qa_data.size() - b); else passed++;
        d0 = na_done;
        send(3'd4, 5'd0, 5'd0, 5'd0, 16'h7, 1'b1);
        wait_done(1'b0, d0);
        total++; if (qa_data.size() - b !== 1) $display("FAIL rm_nwrites got %0d want 1", qa_data.size() - b); else passed++;
        total++; if (qa_data[b] !== 32'h20000007 || qa_addr[b] !== 8'h00) $display("FAIL rm_w0 got %h@%h want 20000007@00", qa_data[b], qa_addr[b]); else passed++;
    endtask

    task automatic test_back_to_back();
        int bb = qb_addr.size();
        int d0 = nb_done;
        imem_ready = 1'b1;
        send(3'd4, 5'd0, 5'd0, 5'd0, 16'h1, 1'b0);
        send(3'd4, 5'd0, 5'd0, 5'd0, 16'h2, 1'b0);
        send(3'd4, 5'd0, 5'd0, 5'd0, 16'h3, 1'b1);
        wait_done(1'b1, d0);
        total++; if (qb_addr.size() - bb !== 3) $display("FAIL b2b_nwrites got %0d want 3", qb_addr.size() - bb); else passed++;
        total++; if (qb_addr[bb] !== 8'hFE || qb_addr[bb+1] !== 8'hFF || qb_addr[bb+2] !== 8'h00) $display("FAIL b2b_wrap got %h,%h,%h want fe,ff,00", qb_addr[bb], qb_addr[bb+1], qb_addr[bb+2]); else passed++;
        total++; if (wcount_b !== 9'd3) $display("FAIL b2b_wcount1 got %0d want 3", wcount_b); else passed++;
        total++; if (nb_done - d0 !== 1) $display("FAIL b2b_done1 got %0d pulses want 1", nb_done - d0); else passed++;
        bb = qb_addr.size();
        d0 = nb_done;
        send(3'd4, 5'd0, 5'd0, 5'd0, 16'h9, 1'b1);
        wait_done(1'b1, d0);
        total++; if (qb_addr.size() - bb !== 1 || qb_addr[bb] !== 8'hFE) $display("FAIL b2b_restart got %0d writes @%h want 1 @fe", qb_addr.size() - bb, qb_addr[bb]); else passed++;
        total++; if (wcount_b !== 9'd1) $display("FAIL b2b_wcount2 got %0d want 1", wcount_b); else passed++;
        total++; if (nb_done - d0 !== 1) $display("FAIL b2b_done2 got %0d pulses want 1", nb_done - d0); else passed++;
    endtask

    initial begin
        test_reset();
        test_encode();
        test_all_ops();
        test_backpressure();
        test_invalid();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
